// File: rtl/mem_bus_master_if.sv
// rtl/mem_bus_master_if.sv - cache request/response and C2 bus signal bundle
// master: view of the bus master itself; slave: view of the cache controller
// and memory model that surround it.
interface mem_bus_master_if #(
  parameter int ADDR_W    = 15,
  parameter int BUS_SIZE  = 16,
  parameter int LINE_BITS = 128
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_W-1:0]    req_addr;
  logic [LINE_BITS-1:0] req_wdata;
  logic                 resp_valid;
  logic [LINE_BITS-1:0] resp_rdata;
  logic                 resp_err;
  logic [ADDR_W-1:0]    c2_addr;
  logic [1:0]           c2_cmd_out;
  logic [1:0]           c2_cmd_in;
  logic [BUS_SIZE-1:0]  c2_dout;
  logic [BUS_SIZE-1:0]  c2_din;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, c2_cmd_in, c2_din,
    output req_ready, resp_valid, resp_rdata, resp_err, c2_addr, c2_cmd_out, c2_dout
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, c2_cmd_in, c2_din,
    input  req_ready, resp_valid, resp_rdata, resp_err, c2_addr, c2_cmd_out, c2_dout
  );
endinterface

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - cache-side C2 bus master, one line transaction at a time
// Turns a 128-bit line fill or write-back into 16-bit C2 beats.
// Optional watchdog: define MEM_TIMEOUT_EN to end stalled transfers with resp_err.
module mem_bus_master #(
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int BUS_SIZE          = 16,
  parameter int CACHE_LINE_SIZE   = 16,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_master_if.master bus
);
  localparam int ADDR_W    = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
  localparam int LINE_BITS = CACHE_LINE_SIZE * 8;
  localparam int BEATS     = LINE_BITS / BUS_SIZE;
  localparam int CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] C2_NOP      = 2'd0;
  localparam logic [1:0] C2_RESPONSE = 2'd1;
  localparam logic [1:0] C2_READ     = 2'd2;
  localparam logic [1:0] C2_WRITE    = 2'd3;

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, WR_WAIT, DONE} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic [ADDR_W-1:0]    addr_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic [LINE_BITS-1:0] rdata_q;
  logic [1:0]           cmd;
  logic                 accept;
  logic                 rsp;
  logic                 timeout;

  assign accept = bus.req_valid && (state == IDLE);
  assign rsp    = (bus.c2_cmd_in == C2_RESPONSE);

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  logic            waiting;

  assign waiting = (state == RD_DATA) || (state == WR_WAIT);
  assign timeout = waiting && !rsp && (to_cnt == TO_LAST);

  // Watchdog: counts silent cycles while waiting on memory, any RESPONSE restarts it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (waiting && !rsp) ? to_cnt + 1'b1 : '0;
      if (accept)
        err_q <= 1'b0;
      else if (timeout)
        err_q <= 1'b1;
    end
  end

  assign bus.resp_err = (state == DONE) && err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout      = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  // State register; reset aborts any transfer and parks the bus at NOP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next-state and C2 command decode
  always_comb begin
    state_n = state;
    cmd     = C2_NOP;
    case (state)
      IDLE: begin
        if (accept)
          state_n = bus.req_write ? WR_DATA : RD_CMD;
      end
      RD_CMD: begin
        cmd     = C2_READ;
        state_n = RD_DATA;
      end
      RD_DATA: begin
        cmd = C2_READ;
        if ((rsp && (cnt == LAST_BEAT)) || timeout)
          state_n = DONE;
      end
      WR_DATA: begin
        cmd = C2_WRITE;
        if (cnt == LAST_BEAT)
          state_n = WR_WAIT;
      end
      WR_WAIT: begin
        if (rsp || timeout)
          state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Request latch, beat counter and read-line assembly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        // A fill starts from a clean line so a timed-out read returns zeros in missing beats
        if (!bus.req_write)
          rdata_q <= '0;
      end
      if ((state == RD_DATA) && rsp) begin
        rdata_q[int'(cnt)*BUS_SIZE +: BUS_SIZE] <= bus.c2_din;
        cnt <= cnt + 1'b1;
      end
      if (state == WR_DATA)
        cnt <= cnt + 1'b1;
      if (timeout)
        cnt <= '0;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_rdata = rdata_q;
  assign bus.c2_addr    = addr_q;
  assign bus.c2_cmd_out = cmd;
  assign bus.c2_dout    = (state == WR_DATA) ? wdata_q[int'(cnt)*BUS_SIZE +: BUS_SIZE] : '0;
endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - directed scoreboard bench for mem_bus_master
module tb_mem_bus_master;
  localparam int ADDR_W = 15;
  localparam int BUS    = 16;
  localparam int LB     = 128;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [LB-1:0]  line_q[$];
  logic [BUS-1:0] beat_q[$];
  logic [LB-1:0]  last_line = '0;

  mem_bus_master_if #(.ADDR_W(ADDR_W), .BUS_SIZE(BUS), .LINE_BITS(LB)) bus ();

  mem_bus_master u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.c2_cmd_in = 2'd0;
    bus.c2_din    = '0;
  endtask

  // Line fill; memory answers one beat per cycle from the first RD_DATA cycle,
  // with an optional stall (non-RESPONSE command on the bus) after beat 3.
  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [BUS-1:0] base,
                         input int gap, input bit hold, input int exp_cyc);
    logic [LB-1:0] exp_line;
    int b = 0;
    int gap_left = gap;
    int cyc;
    bit done = 1'b0;
    for (int i = 0; i < 8; i++) exp_line[i*BUS +: BUS] = base + BUS'(i);
    line_q.push_back(exp_line);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr;
    bus.c2_cmd_in = 2'd0;
    step();
    cyc = 1;
    if (!hold) bus.req_valid = 1'b0;
    chk("rd_ready_busy", bus.req_ready, 0);
    chk("rd_cmd_read", bus.c2_cmd_out, 2);
    chk("rd_addr", bus.c2_addr, addr);
    // stray RESPONSE during RD_CMD must not be captured
    bus.c2_cmd_in = 2'd1;
    bus.c2_din    = 16'hDEAD;
    while (!done && cyc < 200) begin
      step();
      cyc++;
      if (bus.resp_valid) begin
        done = 1'b1;
      end else if (b == 4 && gap_left > 0) begin
        bus.c2_cmd_in = 2'd3;
        bus.c2_din    = 16'hBEEF;
        gap_left--;
      end else if (b < 8) begin
        bus.c2_cmd_in = 2'd1;
        bus.c2_din    = base + BUS'(b);
        b++;
      end else begin
        bus.c2_cmd_in = 2'd0;
        bus.c2_din    = '0;
      end
    end
    chk("rd_done", done, 1);
    exp_line = line_q.pop_front();
    if (done) begin
      chk("rd_rdata", bus.resp_rdata, exp_line);
      chk("rd_latency", cyc, exp_cyc);
      chk("rd_err", bus.resp_err, 0);
      last_line = exp_line;
      bus.c2_cmd_in = 2'd0;
      step();
      chk("rd_pulse_end", bus.resp_valid, 0);
      chk("rd_ready_back", bus.req_ready, 1);
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [LB-1:0] wd, input int delay);
    for (int i = 0; i < 8; i++) beat_q.push_back(wd[i*BUS +: BUS]);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    step();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 8; i++) begin
      chk("wr_cmd_write", bus.c2_cmd_out, 3);
      chk("wr_dout", bus.c2_dout, beat_q.pop_front());
      chk("wr_addr", bus.c2_addr, addr);
      step();
    end
    chk("wr_wait_nop", bus.c2_cmd_out, 0);
    for (int j = 0; j < delay; j++) begin
      chk("wr_wait_noresp", bus.resp_valid, 0);
      step();
    end
    bus.c2_cmd_in = 2'd1;
    step();
    bus.c2_cmd_in = 2'd0;
    chk("wr_resp_valid", bus.resp_valid, 1);
    chk("wr_ready_done", bus.req_ready, 0);
    chk("wr_rdata_kept", bus.resp_rdata, last_line);
    step();
    chk("wr_pulse_end", bus.resp_valid, 0);
    chk("wr_ready_back", bus.req_ready, 1);
  endtask

  initial begin
    logic [LB-1:0] wd;
    bit saw;
    int cyc;
    idle_inputs();
    reset = 1'b0;
    step();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_cmd", bus.c2_cmd_out, 0);
    chk("rst_addr", bus.c2_addr, 0);
    chk("rst_dout", bus.c2_dout, 0);
    reset = 1'b1;
    step();

    // 1: reset in the middle of RD_DATA
    bus.req_valid = 1'b1;
    bus.req_addr  = 15'h0123;
    step();
    bus.req_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.c2_cmd_in = 2'd1;
      bus.c2_din    = 16'hA000 + BUS'(i);
      step();
    end
    chk("mid_cmd_read", bus.c2_cmd_out, 2);
    reset = 1'b0;
    #1;
    chk("abort_cmd_nop", bus.c2_cmd_out, 0);
    chk("abort_ready", bus.req_ready, 1);
    chk("abort_resp_valid", bus.resp_valid, 0);
    chk("abort_rdata", bus.resp_rdata, 0);
    step();
    reset = 1'b1;
    bus.c2_cmd_in = 2'd0;
    saw = 1'b0;
    repeat (12) begin
      step();
      if (bus.resp_valid) saw = 1'b1;
    end
    chk("abort_no_resp", saw, 0);

    // 2: back-to-back read
    do_read(15'h0005, 16'h0000, 0, 1'b0, 10);
    // 3: read with a two-cycle stall after beat 3
    do_read(15'h0005, 16'h0000, 2, 1'b0, 12);
    // 4: write-back to the top line address
    for (int i = 0; i < 8; i++) wd[i*BUS +: BUS] = {8'(2*i+1), 8'(2*i)};
    do_write(15'h7FFF, wd, 3);
    // 5: req_valid held through a transaction -> exactly one more accept
    do_read(15'h0042, 16'h1110, 0, 1'b1, 10);
    do_read(15'h0042, 16'h2220, 0, 1'b0, 10);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held_no_reaccept", bus.c2_cmd_out, 0);
    end

    // 6: memory never responds
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 15'h0077;
    step();
    bus.req_valid = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cyc = 1;
    saw = 1'b0;
    while (!saw && cyc < 200) begin
      step();
      cyc++;
      if (bus.resp_valid) saw = 1'b1;
    end
    chk("to_resp_valid", saw, 1);
    chk("to_latency", cyc, 66);
    chk("to_err", bus.resp_err, 1);
    chk("to_rdata", bus.resp_rdata, 0);
    chk("to_cmd_nop", bus.c2_cmd_out, 0);
`else
    saw = 1'b0;
    repeat (100) begin
      step();
      if (bus.resp_valid) saw = 1'b1;
    end
    chk("stall_no_resp", saw, 0);
    chk("stall_cmd_read", bus.c2_cmd_out, 2);
    chk("stall_ready", bus.req_ready, 0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("stall_recover_ready", bus.req_ready, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
